// File: rtl/dlc_pkg.sv
// Shared types and helpers for the delay-line controller: FSM states,
// per-stage tap decode and the counter saturation constant.
package dlc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      LAUNCH,
      WAIT,
      DRAIN,
      DONE
   } dlc_state_e;

   typedef struct packed {
      logic on;
      logic lb;
   } dlc_ctl_t;

   // All-ones reference; each instance slices it down to its counter width.
   localparam logic [31:0] DLC_CNT_SAT_ALL = '1;

   // Controls of one stage for loop-back tap k: forward below k-1, loop back at k-1.
   function automatic dlc_ctl_t dlc_tap_decode(input int unsigned stage,
                                               input int unsigned tap);
      dlc_ctl_t ctl;
      ctl.on = (stage + 1 < tap);
      ctl.lb = (stage + 1 == tap);
      return ctl;
   endfunction

endpackage

// File: rtl/dlc_sync2.sv
// Two-flop synchroniser for the asynchronous return path of the delay chain.
module dlc_sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/delay_line_ctrl.sv
// Delay-line controller: sets per-stage on/lb controls, launches a start pulse
// and times its return. Define DLC_AVG_EN to accumulate 2**AVG_LOG2 passes.
module delay_line_ctrl
   import dlc_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 64,
   parameter int unsigned SEL_W      = 7,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned SETTLE_CYC = 8,
   parameter int unsigned TIMEOUT    = 1023,
   parameter int unsigned AVG_LOG2   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [SEL_W-1:0]      cmd_tap,
   output logic [NUM_STAGES-1:0] stage_on,
   output logic [NUM_STAGES-1:0] stage_lb,
   output logic                  start_pulse,
   input  logic                  return_in,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [CNT_W-1:0]      res_cycles,
   output logic                  res_timeout,
   output logic                  res_badtap
);

`ifdef DLC_AVG_EN
   localparam int unsigned NPASS = 1 << AVG_LOG2;
`else
   localparam int unsigned NPASS = 1;
`endif
   localparam int unsigned         PASS_W    = AVG_LOG2 + 1;
   localparam logic [PASS_W-1:0]   LAST_PASS = PASS_W'(NPASS - 1);
   localparam logic [CNT_W-1:0]    CNT_SAT   = DLC_CNT_SAT_ALL[CNT_W-1:0];
   localparam logic [CNT_W-1:0]    TMO       = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]    SET_C     = CNT_W'(SETTLE_CYC);

   dlc_state_e              state_q;
   logic                    cmd_ready_q;
   logic                    start_q;
   logic                    res_valid_q;
   logic                    timeout_q;
   logic                    badtap_q;
   logic [NUM_STAGES-1:0]   on_q;
   logic [NUM_STAGES-1:0]   lb_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        tmr_q;
   logic [CNT_W-1:0]        res_q;
   logic [PASS_W-1:0]       pass_q;
   logic                    ret_prev_q;

   logic                    ret_s;
   logic                    ret_rise;
   logic                    tap_good;
   logic [CNT_W-1:0]        cnt_d;
   logic [CNT_W-1:0]        tmr_d;
   logic [CNT_W-1:0]        res_d;
   logic [CNT_W:0]          res_wide;
   logic [NUM_STAGES-1:0]   on_dec;
   logic [NUM_STAGES-1:0]   lb_dec;
   dlc_ctl_t                ctl;

   dlc_sync2 u_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (return_in),
      .q_o    (ret_s)
   );

   assign ret_rise = ret_s & ~ret_prev_q;
   assign tap_good = (cmd_tap != '0) && (32'(cmd_tap) <= NUM_STAGES);
   assign cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
   assign tmr_d    = tmr_q + CNT_W'(1);
   // cnt_d counts the current WAIT cycle too, so a result is the inclusive cycle count.
   assign res_wide = {1'b0, res_q} + {1'b0, cnt_d};
   assign res_d    = res_wide[CNT_W] ? CNT_SAT : res_wide[CNT_W-1:0];

   always_comb begin
      on_dec = '0;
      lb_dec = '0;
      ctl    = '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
         ctl       = dlc_tap_decode(i, 32'(cmd_tap));
         on_dec[i] = ctl.on;
         lb_dec[i] = ctl.lb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ret_prev_q <= 1'b0;
      end else begin
         ret_prev_q <= ret_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         start_q     <= 1'b0;
         res_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         badtap_q    <= 1'b0;
         on_q        <= '0;
         lb_q        <= '0;
         cnt_q       <= '0;
         tmr_q       <= '0;
         res_q       <= '0;
         pass_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  res_q       <= '0;
                  timeout_q   <= 1'b0;
                  tmr_q       <= '0;
                  pass_q      <= '0;
                  if (tap_good) begin
                     badtap_q <= 1'b0;
                     on_q     <= on_dec;
                     lb_q     <= lb_dec;
                     state_q  <= SETTLE;
                  end else begin
                     badtap_q    <= 1'b1;
                     res_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            SETTLE: begin
               tmr_q <= tmr_d;
               if (tmr_d >= SET_C) begin
                  start_q <= 1'b1;
                  state_q <= LAUNCH;
               end
            end
            LAUNCH: begin
               start_q <= 1'b0;
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_d;
               if (ret_rise) begin
                  res_q   <= res_d;
                  tmr_q   <= '0;
                  state_q <= DRAIN;
               end else if (cnt_d == TMO) begin
                  res_q     <= res_d;
                  timeout_q <= 1'b1;
                  tmr_q     <= '0;
                  state_q   <= DRAIN;
               end
            end
            DRAIN: begin
               if (!ret_s) begin
                  if (pass_q == LAST_PASS) begin
                     on_q        <= '0;
                     lb_q        <= '0;
                     res_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     pass_q  <= pass_q + PASS_W'(1);
                     start_q <= 1'b1;
                     state_q <= LAUNCH;
                  end
               end else begin
                  tmr_q <= tmr_d;
                  if (tmr_d == TMO) begin
                     timeout_q   <= 1'b1;
                     on_q        <= '0;
                     lb_q        <= '0;
                     res_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign stage_on    = on_q;
   assign stage_lb    = lb_q;
   assign start_pulse = start_q;
   assign res_valid   = res_valid_q;
   assign res_cycles  = res_q;
   assign res_timeout = timeout_q;
   assign res_badtap  = badtap_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl; the return path is modelled by the tasks.
module tb_delay_line_ctrl;

   localparam int unsigned NS = 64;
   localparam int unsigned SW = 7;
   localparam int unsigned CW = 16;
`ifdef DLC_AVG_EN
   localparam int NPASS = 4;
`else
   localparam int NPASS = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [SW-1:0] cmd_tap = '0;
   logic [NS-1:0] stage_on;
   logic [NS-1:0] stage_lb;
   logic          start_pulse;
   logic          return_in = 1'b0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [CW-1:0] res_cycles;
   logic          res_timeout;
   logic          res_badtap;

   int checks = 0;
   int errors = 0;
   int start_total = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (start_pulse === 1'b1) start_total++;

   delay_line_ctrl #(
      .NUM_STAGES (NS),
      .SEL_W      (SW),
      .CNT_W      (CW),
      .SETTLE_CYC (8),
      .TIMEOUT    (1023),
      .AVG_LOG2   (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_tap     (cmd_tap),
      .stage_on    (stage_on),
      .stage_lb    (stage_lb),
      .start_pulse (start_pulse),
      .return_in   (return_in),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_cycles  (res_cycles),
      .res_timeout (res_timeout),
      .res_badtap  (res_badtap)
   );

   task automatic send_cmd(input int tap);
      @(negedge clk);
      cmd_tap   = SW'(tap);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1200 && !ok; i++) begin
         @(negedge clk);
         if (start_pulse === 1'b1) ok = 1'b1;
      end
   endtask

   // Return rises d cycles after each observed start and stays high for h cycles.
   task automatic drive_passes(input int d, input int h, input bit never, input string nm);
      bit ok;
      for (int p = 0; p < NPASS; p++) begin
         wait_start(ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL %s_start: no start_pulse on pass %0d, expected one", nm, p);
            return;
         end
         if (!never) begin
            repeat (d) @(posedge clk);
            #1 return_in = 1'b1;
            repeat (h) @(posedge clk);
            #1 return_in = 1'b0;
         end
      end
   endtask

   task automatic wait_res(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 1500 && !ok; i++) begin
         @(negedge clk);
         if (res_valid === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_resvalid: res_valid got 0 expected 1 within budget", nm);
      end
   endtask

   task automatic consume();
      @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({cmd_ready, start_pulse, res_valid, res_timeout, res_badtap} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 10000",
                  {cmd_ready, start_pulse, res_valid, res_timeout, res_badtap});
      end
      checks++;
      if (stage_on !== '0 || stage_lb !== '0 || res_cycles !== '0) begin
         errors++;
         $display("FAIL reset_data: on %h lb %h cyc %0d expected all 0", stage_on, stage_lb, res_cycles);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_measure(input string nm, input int tap, input int d,
                               input logic [NS-1:0] exp_on, input logic [NS-1:0] exp_lb);
      int st = start_total;
      logic [CW-1:0] exp_cyc = CW'(NPASS * (d + 2));
      send_cmd(tap);
      checks++;
      if (stage_on !== exp_on || stage_lb !== exp_lb || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_ctl: on %h lb %h rdy %b expected on %h lb %h rdy 0",
                  nm, stage_on, stage_lb, cmd_ready, exp_on, exp_lb);
      end
      drive_passes(d, 3, 1'b0, nm);
      wait_res(nm);
      checks++;
      if (res_cycles !== exp_cyc || res_timeout !== 1'b0 || res_badtap !== 1'b0) begin
         errors++;
         $display("FAIL %s_res: cyc %0d to %b bad %b expected cyc %0d to 0 bad 0",
                  nm, res_cycles, res_timeout, res_badtap, exp_cyc);
      end
      checks++;
      if (stage_on !== '0 || stage_lb !== '0 || (start_total - st) !== NPASS) begin
         errors++;
         $display("FAIL %s_done: on %h lb %h starts %0d expected 0 0 %0d",
                  nm, stage_on, stage_lb, start_total - st, NPASS);
      end
      consume();
      checks++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: rdy %b valid %b expected 1 0", nm, cmd_ready, res_valid);
      end
   endtask

   task automatic test_badtap(input int tap);
      int st = start_total;
      send_cmd(tap);
      checks++;
      if (res_valid !== 1'b1 || res_badtap !== 1'b1 || res_cycles !== '0 || res_timeout !== 1'b0) begin
         errors++;
         $display("FAIL badtap%0d_res: valid %b bad %b cyc %0d to %b expected 1 1 0 0",
                  tap, res_valid, res_badtap, res_cycles, res_timeout);
      end
      repeat (12) @(negedge clk);
      checks++;
      if (stage_on !== '0 || stage_lb !== '0 || start_total !== st) begin
         errors++;
         $display("FAIL badtap%0d_quiet: on %h lb %h starts %0d expected 0 0 0",
                  tap, stage_on, stage_lb, start_total - st);
      end
      consume();
   endtask

   task automatic test_timeout();
      logic [CW-1:0] exp_cyc = CW'(NPASS * 1023);
      send_cmd(5);
      drive_passes(0, 0, 1'b1, "timeout");
      wait_res("timeout");
      checks++;
      if (res_cycles !== exp_cyc || res_timeout !== 1'b1 || res_badtap !== 1'b0) begin
         errors++;
         $display("FAIL timeout_res: cyc %0d to %b bad %b expected cyc %0d to 1 bad 0",
                  res_cycles, res_timeout, res_badtap, exp_cyc);
      end
      consume();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL timeout_idle: cmd_ready got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_hold_and_reset();
      logic [CW-1:0] exp_cyc = CW'(NPASS * 4);
      int st;
      bit ok;
      send_cmd(3);
      drive_passes(2, 2, 1'b0, "hold");
      wait_res("hold");
      for (int i = 0; i < 10; i++) begin
         cmd_valid = (i == 3);
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_cycles !== exp_cyc || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_c%0d: valid %b cyc %0d rdy %b expected 1 %0d 0",
                     i, res_valid, res_cycles, cmd_ready, exp_cyc);
         end
      end
      cmd_valid = 1'b0;
      consume();
      st = start_total;
      repeat (14) @(negedge clk);
      checks++;
      if (start_total !== st || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_ignored: starts %0d rdy %b expected 0 1", start_total - st, cmd_ready);
      end
      send_cmd(2);
      wait_start(ok);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, start_pulse, res_valid, res_timeout, res_badtap} !== 5'b10000 ||
          stage_on !== '0 || stage_lb !== '0 || !ok) begin
         errors++;
         $display("FAIL midreset: flags %b on %h lb %h launched %b expected 10000 0 0 1",
                  {cmd_ready, start_pulse, res_valid, res_timeout, res_badtap}, stage_on, stage_lb, ok);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_avg();
      int st = start_total;
      logic [CW-1:0] exp_cyc = CW'(NPASS * 5);
      send_cmd(7);
      drive_passes(3, 2, 1'b0, "avg");
      wait_res("avg");
      checks++;
      if (res_cycles !== exp_cyc || (start_total - st) !== NPASS || res_timeout !== 1'b0) begin
         errors++;
         $display("FAIL avg_res: cyc %0d starts %0d to %b expected %0d %0d 0",
                  res_cycles, start_total - st, res_timeout, exp_cyc, NPASS);
      end
      consume();
   endtask

   initial begin
      logic [NS-1:0] on64;
      logic [NS-1:0] lb64;
      on64 = '1;
      on64[NS-1] = 1'b0;
      lb64 = '0;
      lb64[NS-1] = 1'b1;
      test_reset();
      test_measure("tap1", 1, 5, '0, NS'(1));
      test_measure("tap64", 64, 40, on64, lb64);
      test_badtap(0);
      test_badtap(65);
      test_measure("tap1_after_bad", 1, 5, '0, NS'(1));
      test_timeout();
      test_hold_and_reset();
      test_avg();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
